// File: rtl/global_avg_pool_pkg.sv
// rtl/global_avg_pool_pkg.sv - state type and fixed-point helpers for global_avg_pool
package gap_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    MULT  = 2'd1,
    ROUND = 2'd2
  } gap_state_t;

  // round(2^shift / n), computed at elaboration for the divide-by-N reciprocal
  function automatic int recip(input int n, input int shift);
    return ((1 << shift) + n / 2) / n;
  endfunction

  function automatic longint sat(input longint v, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/global_avg_pool_if.sv
// rtl/global_avg_pool_if.sv - pixel stream in, pooled vector out
interface global_avg_pool_if #(
  parameter int CHANNELS   = 576,
  parameter int DATA_WIDTH = 8
) ();

  logic [0:CHANNELS-1][DATA_WIDTH-1:0] data_in;
  logic                                in_valid;
  logic                                in_last;
  logic                                in_ready;
  logic [0:CHANNELS-1][DATA_WIDTH-1:0] data_out;
  logic                                valid_out;
  logic                                frame_err;
  logic                                busy;

  modport master (
    output data_in, in_valid, in_last,
    input  in_ready, data_out, valid_out, frame_err, busy
  );

  modport slave (
    input  data_in, in_valid, in_last,
    output in_ready, data_out, valid_out, frame_err, busy
  );

endinterface

// File: rtl/global_avg_pool_lane.sv
// rtl/global_avg_pool_lane.sv - per-channel accumulate, reciprocal multiply, round and saturate
module global_avg_pool_lane
  import gap_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_W       = 15,
  parameter int PROD_W      = 32,
  parameter int RECIP_SHIFT = 16,
  parameter int RECIP       = 1337
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic                  mul_en,
  input  logic                  out_en,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic signed [PROD_W-1:0] RECIP_X = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(1) << (RECIP_SHIFT - 1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [PROD_W-1:0] acc_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_rnd;
  logic signed [PROD_W-1:0] q;

  assign din_ext  = {{(ACC_W - DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
  assign acc_x    = {{(PROD_W - ACC_W){acc[ACC_W-1]}}, acc};
  assign prod_rnd = prod + HALF;
  // arithmetic shift floors, so +half gives round-half-up on both signs
  assign q        = prod_rnd >>> RECIP_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      prod <= '0;
      dout <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (acc_en)
        acc <= acc + din_ext;
      if (mul_en)
        prod <= acc_x * RECIP_X;
      if (out_en)
        dout <= DATA_WIDTH'(sat(longint'(q), DATA_WIDTH));
    end
  end

endmodule

// File: rtl/global_avg_pool.sv
// rtl/global_avg_pool.sv - global average pooling: frame FSM, pixel count, error latch, lane array
module global_avg_pool
  import gap_pkg::*;
#(
  parameter int CHANNELS    = 576,
  parameter int HEIGHT      = 7,
  parameter int WIDTH       = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int RECIP_SHIFT = 16
) (
  input logic              clk,
  input logic              rst,
  global_avg_pool_if.slave bus
);

  localparam int N      = HEIGHT * WIDTH;
  localparam int ACC_W  = DATA_WIDTH + $clog2(N) + 1;
  localparam int PROD_W = ACC_W + RECIP_SHIFT + 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int RECIP  = recip(N, RECIP_SHIFT);

  gap_state_t state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic err_latch;
  logic valid_out_r;
  logic frame_err_r;
  logic in_ready;
  logic accept;
  logic last_pix;
  logic clr, acc_en, mul_en, out_en;
  logic [0:CHANNELS-1][DATA_WIDTH-1:0] data_out_w;

  assign accept   = bus.in_valid && in_ready;
  assign last_pix = (pix_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_pix) state_nxt = MULT;
      MULT:    state_nxt = ROUND;
      ROUND:   state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    acc_en   = 1'b0;
    mul_en   = 1'b0;
    out_en   = 1'b0;
    clr      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        acc_en   = bus.in_valid;
      end
      MULT:  mul_en = 1'b1;
      ROUND: begin
        out_en = 1'b1;
        clr    = 1'b1;
      end
      default: ;
    endcase
  end

  // frame length comes from pix_cnt alone; in_last only feeds the error latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt     <= '0;
      err_latch   <= 1'b0;
      valid_out_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      valid_out_r <= out_en;
      frame_err_r <= out_en && err_latch;
      if (clr) begin
        pix_cnt   <= '0;
        err_latch <= 1'b0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (bus.in_last != last_pix)
          err_latch <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    global_avg_pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .PROD_W     (PROD_W),
      .RECIP_SHIFT(RECIP_SHIFT),
      .RECIP      (RECIP)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.data_in[c]),
      .clr   (clr),
      .acc_en(acc_en),
      .mul_en(mul_en),
      .out_en(out_en),
      .dout  (data_out_w[c])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.data_out  = data_out_w;
  assign bus.valid_out = valid_out_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state != ACCUM) || (pix_cnt != '0);

endmodule

// File: tb/tb_global_avg_pool.sv
// tb/tb_global_avg_pool.sv - scoreboard bench for global_avg_pool with directed frames
module tb_global_avg_pool;

  localparam int CH = 576;
  localparam int DW = 8;
  localparam int H  = 7;
  localparam int W  = 7;
  localparam int N  = H * W;

  typedef logic [0:CH-1][DW-1:0] pix_t;
  typedef struct {
    int e0;
    int e1;
    int erest;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  global_avg_pool_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

  global_avg_pool #(
    .CHANNELS   (CH),
    .HEIGHT     (H),
    .WIDTH      (W),
    .DATA_WIDTH (DW),
    .RECIP_SHIFT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_v = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (!rst && bus.valid_out) begin
      check("valid_pulse_width", int'(prev_v), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid_out: got pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        check("ch0", int'($signed(bus.data_out[0])), e.e0);
        check("ch1", int'($signed(bus.data_out[1])), e.e1);
        bad = 0;
        for (int c = 2; c < CH; c++)
          if (int'($signed(bus.data_out[c])) != e.erest) bad++;
        check("rest_bad_channels", bad, 0);
        check("frame_err", int'(bus.frame_err), e.err);
      end
    end
    prev_v = bus.valid_out;
  end

  function automatic pix_t make_pix(input int kind, input int val, input int idx);
    pix_t p;
    for (int c = 0; c < CH; c++) p[c] = DW'(kind == 0 ? val : 0);
    if (kind == 1) begin
      p[0] = DW'(idx);
      p[1] = DW'((idx % 2 == 0) ? 100 : -100);
    end
    return p;
  endfunction

  task automatic send_beat(input pix_t p, input logic last, output int waits);
    bus.data_in  = p;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    waits = 0;
    while (!bus.in_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) check("in_ready_timeout", int'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic send_frame(input int kind, input int val, input int last_a, input int last_b,
                            input bit gaps, output int first_wait);
    int w;
    for (int i = 0; i < N; i++) begin
      send_beat(make_pix(kind, val, i), (i == last_a) || (i == last_b), w);
      if (i == 0) first_wait = w;
      if (gaps && (i % 7 == 3)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int   w;
    int   nz;
    exp_t e;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(negedge clk);

    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    nz = 0;
    for (int c = 0; c < CH; c++) if (bus.data_out[c] != '0) nz++;
    check("rst_data_out_nonzero", nz, 0);
    rst = 1'b0;
    @(negedge clk);

    // all 16 with latency / in_ready timing around the end of frame
    e = '{16, 16, 16, 0}; exp_q.push_back(e);
    send_frame(0, 16, N - 1, -1, 1'b0, w);
    bus.in_valid = 1'b0;
    check("e0_in_ready", int'(bus.in_ready), 0);
    check("e0_valid_out", int'(bus.valid_out), 0);
    check("e0_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("e1_in_ready", int'(bus.in_ready), 0);
    check("e1_valid_out", int'(bus.valid_out), 0);
    @(negedge clk);
    check("e2_valid_out", int'(bus.valid_out), 1);
    check("e2_in_ready", int'(bus.in_ready), 1);
    check("e2_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("e3_valid_cleared", int'(bus.valid_out), 0);

    // back-to-back frames with in_valid held high: 127 then -128
    e = '{127, 127, 127, 0}; exp_q.push_back(e);
    send_frame(0, 127, N - 1, -1, 1'b0, w);
    e = '{-128, -128, -128, 0}; exp_q.push_back(e);
    send_frame(0, -128, N - 1, -1, 1'b0, w);
    check("b2b_first_beat_waits", w, 2);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // ramp on ch0, alternating +/-100 on ch1, with idle gaps mid-frame
    e = '{24, 2, 0, 0}; exp_q.push_back(e);
    send_frame(1, 0, N - 1, -1, 1'b1, w);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // early in_last on beat 10: frame still 49 beats, error flagged
    e = '{16, 16, 16, 1}; exp_q.push_back(e);
    send_frame(0, 16, 9, N - 1, 1'b0, w);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // missing in_last on the final beat, negative mean rounds to -5
    e = '{-5, -5, -5, 1}; exp_q.push_back(e);
    send_frame(0, -5, -1, -1, 1'b0, w);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // abort after 20 beats with reset, then a clean frame
    for (int i = 0; i < 20; i++) send_beat(make_pix(0, 100, i), 1'b0, w);
    bus.in_valid = 1'b0;
    check("mid_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort_data_out0", int'($signed(bus.data_out[0])), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_valid_out", int'(bus.valid_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    e = '{16, 16, 16, 0}; exp_q.push_back(e);
    send_frame(0, 16, N - 1, -1, 1'b0, w);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
